// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

   localparam int   DEFAULT_DATA_WIDTH   = 8;
   localparam int   DEFAULT_CLKS_PER_BIT = 868;
   localparam logic IDLE_LEVEL           = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps,
// flagging the last cycle of each bit period on bit_end.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   assign bit_end = enable && (cnt_q == LAST);

   // Clear has priority so every bit period starts counting from zero.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even parity,
// one stop bit. Optional build macro: UART_TX_PARITY_EN.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  txd,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_state_t           state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  txd_q, txd_d;
   logic                  bit_end;
   logic                  cnt_clear;
   logic                  cnt_en;

   // The counter idles at zero so each frame's start bit gets a full period.
   assign cnt_clear = rst || (state_q == IDLE);
   assign cnt_en    = (state_q != IDLE);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk    (clk),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .bit_end(bit_end)
   );

   assign txd  = txd_q;
   assign busy = (state_q != IDLE);

   // Next-state, next-line-level and FIFO pop decode.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      txd_d      = txd_q;
      fifo_rd_en = 1'b0;
      tx_done    = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = IDLE_LEVEL;
            // A pop during reset would lose the byte, so rst blocks it.
            if (!fifo_empty && !rst) begin
               fifo_rd_en = 1'b1;
               shift_d    = fifo_dout;
               idx_d      = '0;
               state_d    = START;
               txd_d      = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = ^shift_q;
`else
                  state_d = STOP;
                  txd_d   = IDLE_LEVEL;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
                  txd_d = shift_q[idx_d];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               txd_d   = IDLE_LEVEL;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               tx_done = 1'b1;
               state_d = IDLE;
               txd_d   = IDLE_LEVEL;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = IDLE_LEVEL;
         end
      endcase
   end

   // State, captured byte, bit index and registered serial line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         txd_q   <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4, DATA_WIDTH=8.
// Expected line activity is built frame by frame from the frame format;
// with UART_TX_PARITY_EN defined the frames include an even-parity bit.
module tb_uart_tx;

   localparam int CPB = 4;

   typedef struct packed {
      logic txd;
      logic busy;
      logic done;
      logic rd;
   } smp_t;

   logic       clk;
   logic       rst;
   logic [7:0] fifo_dout;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic       txd;
   logic       busy;
   logic       tx_done;

   logic [7:0] mem [0:63];
   logic [5:0] head, tail;
   logic       corrupt;
   logic [7:0] c_dout;
   logic       c_empty;
   logic       pop_pend;
   int         pop_err;

   smp_t trace[$];
   smp_t exp[$];
   int   errors;
   int   checks;

   uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_dout (fifo_dout),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .txd       (txd),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO head presentation; corrupt mode drives junk to prove it is ignored.
   always_comb begin
      if (corrupt) begin
         fifo_empty = c_empty;
         fifo_dout  = c_dout;
      end else begin
         fifo_empty = (head == tail);
         fifo_dout  = mem[head];
      end
   end

   // Record DUT outputs mid-cycle.
   always @(negedge clk) begin
      trace.push_back(smp_t'({txd, busy, tx_done, fifo_rd_en}));
      pop_pend = fifo_rd_en;
   end

   // Pop the FIFO model just after the edge that consumed the head.
   always @(posedge clk) begin
      #1;
      if (pop_pend) begin
         if (head == tail) pop_err++;
         else head = head + 1'b1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[tail] = b;
      tail = tail + 1'b1;
   endtask

   task automatic exp_idle(input logic rd);
      exp.push_back('{txd: 1'b1, busy: 1'b0, done: 1'b0, rd: rd});
   endtask

   task automatic exp_frame(input logic [7:0] b);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
      for (int k = 0; k < bits.size(); k++)
         for (int c = 0; c < CPB; c++)
            exp.push_back('{txd: bits[k], busy: 1'b1,
                            done: (k == bits.size() - 1) && (c == CPB - 1), rd: 1'b0});
   endtask

   task automatic start_test();
      @(posedge clk);
      #2;
      trace.delete();
      exp.delete();
   endtask

   task automatic check_trace(input string tag);
      int waited = 0;
      while (trace.size() < exp.size() && waited < exp.size() + 100) begin
         @(posedge clk);
         waited++;
      end
      checks++;
      assert (trace.size() >= exp.size()) else begin
         errors++;
         $error("FAIL %s timeout: got %0d samples, required %0d", tag, trace.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < trace.size(); i++) begin
         checks++;
         assert (trace[i] === exp[i]) else begin
            errors++;
            $error("FAIL %s cyc %0d: txd/busy/done/rd got %b required %b", tag, i, trace[i], exp[i]);
         end
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      pop_err  = 0;
      pop_pend = 1'b0;
      head     = '0;
      tail     = '0;
      corrupt  = 1'b0;
      c_dout   = '0;
      c_empty  = 1'b1;
      rst      = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      repeat (2) @(posedge clk);

      // Reset holds the line idle and blocks popping; first free cycle pops 0x55.
      start_test();
      push(8'h55);
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b0;
      exp.push_back('{txd: 1'b1, busy: 1'b0, done: 1'b0, rd: 1'b0});
      exp.push_back('{txd: 1'b1, busy: 1'b0, done: 1'b0, rd: 1'b0});
      exp_idle(1'b1);
      exp_frame(8'h55);
      repeat (3) exp_idle(1'b0);
      check_trace("reset_then_0x55");

      // Empty FIFO: line stays quiet.
      start_test();
      repeat (200) exp_idle(1'b0);
      check_trace("empty_idle");

      // Back-to-back frames separated by one idle cycle.
      start_test();
      push(8'hA3);
      push(8'h0F);
      exp_idle(1'b1);
      exp_frame(8'hA3);
      exp_idle(1'b1);
      exp_frame(8'h0F);
      repeat (3) exp_idle(1'b0);
      check_trace("b2b_A3_0F");

      // Parity-sensitive pair.
      start_test();
      push(8'h07);
      push(8'h03);
      exp_idle(1'b1);
      exp_frame(8'h07);
      exp_idle(1'b1);
      exp_frame(8'h03);
      repeat (2) exp_idle(1'b0);
      check_trace("parity_07_03");

      // Random burst.
      start_test();
      exp_idle(1'b1);
      for (int n = 0; n < 5; n++) begin
         logic [7:0] b;
         b = 8'($urandom);
         push(b);
         exp_frame(b);
         exp_idle(n < 4);
      end
      repeat (2) exp_idle(1'b0);
      check_trace("random_burst");

      // FIFO inputs thrashed mid-frame: captured byte must go out unchanged.
      start_test();
      push(8'h3C);
      repeat (8) begin
         @(posedge clk);
         #2;
      end
      corrupt = 1'b1;
      repeat (25) begin
         c_dout  = 8'($urandom);
         c_empty = 1'($urandom_range(0, 1));
         @(posedge clk);
         #2;
      end
      corrupt = 1'b0;
      exp_idle(1'b1);
      exp_frame(8'h3C);
      repeat (3) exp_idle(1'b0);
      check_trace("midframe_corrupt");

      // Reset pulse during frame cycle 17 of 0xFF; next byte goes out cleanly.
      start_test();
      push(8'hFF);
      push(8'h5A);
      repeat (17) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      exp_idle(1'b1);
      exp_frame(8'hFF);
      while (exp.size() > 18) void'(exp.pop_back());
      exp_idle(1'b1);
      exp_frame(8'h5A);
      repeat (2) exp_idle(1'b0);
      check_trace("reset_midframe");

      checks++;
      assert (pop_err == 0) else begin
         errors++;
         $error("FAIL pop_when_empty: got %0d pops of an empty FIFO, required 0", pop_err);
      end
      checks++;
      assert (head === tail) else begin
         errors++;
         $error("FAIL fifo_drained: head %0d tail %0d, required equal", head, tail);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, the clk cycles per serial bit period; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fifo_dout, input, DATA_WIDTH, the head byte of a first-word-fall-through FIFO, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_empty, input, 1, high when the FIFO holds no data.
REQ-007 SHALL have port fifo_rd_en, output, 1, a one-cycle pop strobe to the FIFO.
REQ-008 SHALL have port txd, output, 1, the serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high from the cycle after a pop through the last stop-bit cycle.
REQ-010 SHALL have port tx_done, output, 1, a one-cycle pulse in the final stop-bit cycle.

Function
REQ-011 SHALL use the FSM states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-024.
REQ-012 In IDLE with fifo_empty=0, SHALL assert fifo_rd_en for exactly one cycle, capture fifo_dout into the shift register on that edge, and enter START.
REQ-013 SHALL never assert fifo_rd_en while fifo_empty=1 or outside IDLE.
REQ-014 SHALL register txd; txd goes low on the first START cycle, one cycle after the fifo_rd_en pulse.
REQ-015 SHALL hold each bit (start, each data bit, parity, stop) for exactly CLKS_PER_BIT cycles, timed by a bit counter that runs 0..CLKS_PER_BIT-1 and wraps.
REQ-016 SHALL send data bits LSB first; a 3-bit (clog2 DATA_WIDTH) index counts 0..DATA_WIDTH-1, then DATA exits.
REQ-017 SHALL send one stop bit (txd=1); at its final cycle tx_done=1 and the FSM enters IDLE.
REQ-018 Back-to-back frames: exactly one IDLE cycle (txd=1) SHALL separate consecutive frames while the FIFO stays non-empty.
REQ-019 SHALL ignore changes on fifo_dout and fifo_empty outside IDLE; the captured byte is transmitted unaltered.
REQ-020 Frame length (first start cycle to last stop cycle) SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.

Reset
REQ-021 On clk edge with rst=1, SHALL set state=IDLE, txd=1, fifo_rd_en=0, busy=0, tx_done=0, and clear the bit counter, bit index and shift register.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 next cycle) and SHALL not pop the FIFO again for the aborted byte.
REQ-023 In the first cycle after rst deasserts with fifo_empty=0, SHALL behave as IDLE per REQ-012.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of data bits) for CLKS_PER_BIT cycles; undefined, DATA SHALL go directly to STOP and no parity logic is synthesized.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT and DATA_WIDTH constants, and the idle-line level constant.
REQ-026 Sub-module uart_baud_cnt SHALL implement the per-bit cycle counter with inputs clear and enable and output bit_end; the FSM lives in uart_tx.

Verification
REQ-027 CLKS_PER_BIT=4, byte 0x55 -> one fifo_rd_en pulse; txd = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total); tx_done pulses at cycle 40.
REQ-028 FIFO empty for 200 cycles -> txd=1, fifo_rd_en=0, busy=0 throughout.
REQ-029 Bytes 0xA3 and 0x0F queued, CLKS_PER_BIT=4 -> two pops 41 cycles apart; a single idle-high cycle between frames; serial bits match LSB first.
REQ-030 rst pulsed at cycle 17 of a 0xFF frame -> txd=1 and busy=0 on the next cycle; no extra pop; the next queued byte is sent cleanly.
REQ-031 UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-032 fifo_dout changed mid-frame -> the transmitted bits equal the byte captured at the pop.
